// File: rtl/traffic_conflict_monitor.sv
// Safety monitor for a two-approach traffic light: detects conflicting, multi-lit, dark and
// short-yellow lamp patterns, latches the first fault and drives a flashing-red override until cleared.
`timescale 1ns/1ps
module traffic_conflict_monitor #(
  parameter int YELLOW_MIN = 3,
  parameter int DARK_TOL   = 2,
  parameter int FLASH_HALF = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       north_green,
  input  logic       north_yellow,
  input  logic       north_red,
  input  logic       east_green,
  input  logic       east_yellow,
  input  logic       east_red,
  input  logic       fault_clr,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic       override,
  output logic       flash_red,
  output logic [7:0] fault_count
);

  localparam int YW = $clog2(YELLOW_MIN + 2);
  localparam int DW = $clog2(DARK_TOL + 2);
  localparam int FW = $clog2(FLASH_HALF + 1);

  // Lamp vectors are {green, yellow, red}.
  localparam logic [2:0] RED_ONLY    = 3'b001;
  localparam logic [2:0] YELLOW_ONLY = 3'b010;
  localparam logic [2:0] GREEN_ONLY  = 3'b100;

  localparam logic [2:0] CODE_NONE     = 3'd0;
  localparam logic [2:0] CODE_CONFLICT = 3'd1;
  localparam logic [2:0] CODE_MULTI    = 3'd2;
  localparam logic [2:0] CODE_DARK     = 3'd3;
  localparam logic [2:0] CODE_SHORT_Y  = 3'd4;

  typedef enum logic {MONITOR, FAULT} state_e;

  state_e          state_q, state_d;
  logic [2:0]      prevLamp_q [2];
  logic [2:0]      prevLamp_d [2];
  logic [YW-1:0]   yCnt_q [2];
  logic [YW-1:0]   yCnt_d [2];
  logic [DW-1:0]   dCnt_q [2];
  logic [DW-1:0]   dCnt_d [2];
  logic [2:0]      code_q, code_d;
  logic            flash_q, flash_d;
  logic [FW-1:0]   flashCnt_q, flashCnt_d;
  logic [7:0]      count_q, count_d;

  logic [2:0]      lamps [2];
  logic            conflict;
  logic [1:0]      multiLamp, darkFault, shortYellow;
  logic            bothRed;
  logic [2:0]      winCode;

  assign lamps[0] = {north_green, north_yellow, north_red};
  assign lamps[1] = {east_green, east_yellow, east_red};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= MONITOR;
      prevLamp_q <= '{RED_ONLY, RED_ONLY};
      yCnt_q     <= '{default: '0};
      dCnt_q     <= '{default: '0};
      code_q     <= CODE_NONE;
      flash_q    <= 1'b0;
      flashCnt_q <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      prevLamp_q <= prevLamp_d;
      yCnt_q     <= yCnt_d;
      dCnt_q     <= dCnt_d;
      code_q     <= code_d;
      flash_q    <= flash_d;
      flashCnt_q <= flashCnt_d;
      count_q    <= count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    prevLamp_d  = prevLamp_q;
    yCnt_d      = yCnt_q;
    dCnt_d      = dCnt_q;
    code_d      = code_q;
    flash_d     = flash_q;
    flashCnt_d  = flashCnt_q;
    count_d     = count_q;
    multiLamp   = '0;
    darkFault   = '0;
    shortYellow = '0;
    bothRed     = 1'b1;
    winCode     = CODE_NONE;

    conflict = (|lamps[0][2:1]) & (|lamps[1][2:1]);
    for (int i = 0; i < 2; i++) begin
      multiLamp[i]   = (lamps[i][2] & lamps[i][1]) | (lamps[i][2] & lamps[i][0]) |
                       (lamps[i][1] & lamps[i][0]);
      // The counter already holds DARK_TOL dark cycles, so this sample is one too many.
      darkFault[i]   = (lamps[i] == 3'b000) && (dCnt_q[i] >= DW'(DARK_TOL));
      shortYellow[i] = (lamps[i] == RED_ONLY) &&
                       ((prevLamp_q[i] == GREEN_ONLY) ||
                        ((prevLamp_q[i] == YELLOW_ONLY) && (yCnt_q[i] < YW'(YELLOW_MIN))));
      if (lamps[i] != RED_ONLY) bothRed = 1'b0;
    end

    if (conflict)              winCode = CODE_CONFLICT;
    else if (|multiLamp)       winCode = CODE_MULTI;
    else if (|darkFault)       winCode = CODE_DARK;
    else if (|shortYellow)     winCode = CODE_SHORT_Y;

    case (state_q)
      MONITOR: begin
        for (int i = 0; i < 2; i++) begin
          prevLamp_d[i] = lamps[i];
          if (!lamps[i][1])                       yCnt_d[i] = '0;
          else if (yCnt_q[i] != YW'(YELLOW_MIN))  yCnt_d[i] = yCnt_q[i] + 1'b1;
          if (lamps[i] != 3'b000)                 dCnt_d[i] = '0;
          else if (dCnt_q[i] != DW'(DARK_TOL))    dCnt_d[i] = dCnt_q[i] + 1'b1;
        end
        if (winCode != CODE_NONE) begin
          state_d    = FAULT;
          code_d     = winCode;
          flash_d    = 1'b1;
          flashCnt_d = '0;
          if (count_q != 8'hFF) count_d = count_q + 8'd1;
        end
      end
      FAULT: begin
        // Clearing is only safe once the controller itself shows red-only on both approaches.
        if (fault_clr && bothRed) begin
          state_d    = MONITOR;
          code_d     = CODE_NONE;
          flash_d    = 1'b0;
          flashCnt_d = '0;
          prevLamp_d = '{RED_ONLY, RED_ONLY};
          yCnt_d     = '{default: '0};
          dCnt_d     = '{default: '0};
        end else if (flashCnt_q == FW'(FLASH_HALF - 1)) begin
          flash_d    = ~flash_q;
          flashCnt_d = '0;
        end else begin
          flashCnt_d = flashCnt_q + 1'b1;
        end
      end
      default: state_d = MONITOR;
    endcase
  end

  assign fault       = (state_q == FAULT);
  assign override    = (state_q == FAULT);
  assign fault_code  = code_q;
  assign flash_red   = flash_q;
  assign fault_count = count_q;

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Scoreboard bench for traffic_conflict_monitor: a behavioural model predicts each cycle's outputs,
// which are queued at drive time and compared on the following falling edge.
`timescale 1ns/1ps
module tb_traffic_conflict_monitor;

  localparam int YELLOW_MIN = 3;
  localparam int DARK_TOL   = 2;
  localparam int FLASH_HALF = 4;

  localparam logic [2:0] RED  = 3'b001;
  localparam logic [2:0] YEL  = 3'b010;
  localparam logic [2:0] GRN  = 3'b100;
  localparam logic [2:0] DARK = 3'b000;

  typedef struct packed {
    logic       fault;
    logic       override;
    logic [2:0] code;
    logic       flash;
    logic [7:0] count;
  } expect_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       northGreen = 1'b0, northYellow = 1'b0, northRed = 1'b1;
  logic       eastGreen = 1'b0, eastYellow = 1'b0, eastRed = 1'b1;
  logic       faultClr = 1'b0;
  logic       fault, override, flashRed;
  logic [2:0] faultCode;
  logic [7:0] faultCount;

  int checksDone = 0;
  int checksFailed = 0;
  expect_t sb[$];

  int mFault, mCode, mFlash, mFlashCnt, mCount;
  int yRun [2];
  int darkRun [2];
  int prevKind [2];

  traffic_conflict_monitor #(
    .YELLOW_MIN(YELLOW_MIN), .DARK_TOL(DARK_TOL), .FLASH_HALF(FLASH_HALF)
  ) dut (
    .clk(clk), .rst(rst),
    .north_green(northGreen), .north_yellow(northYellow), .north_red(northRed),
    .east_green(eastGreen), .east_yellow(eastYellow), .east_red(eastRed),
    .fault_clr(faultClr), .fault(fault), .fault_code(faultCode),
    .override(override), .flash_red(flashRed), .fault_count(faultCount)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checksDone++;
    if (obs !== exp) begin
      checksFailed++;
      $display("[TB] FAIL %s: observed %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Kinds: 0 other, 1 red-only, 2 yellow-only, 3 green-only.
  function automatic int kindOf(input logic [2:0] l);
    if (l == RED) return 1;
    if (l == YEL) return 2;
    if (l == GRN) return 3;
    return 0;
  endfunction

  task automatic modelReset();
    mFault = 0; mCode = 0; mFlash = 0; mFlashCnt = 0; mCount = 0;
    for (int i = 0; i < 2; i++) begin
      yRun[i] = 0; darkRun[i] = 0; prevKind[i] = 1;
    end
  endtask

  task automatic modelStep(input logic [2:0] n, input logic [2:0] e, input logic clr);
    logic [2:0] lamp [2];
    bit conflictF, multiF, darkF, shortF;
    int lit;
    lamp[0] = n;
    lamp[1] = e;
    if (mFault == 0) begin
      conflictF = (n[2] | n[1]) && (e[2] | e[1]);
      multiF = 0; darkF = 0; shortF = 0;
      for (int i = 0; i < 2; i++) begin
        lit = $countones(lamp[i]);
        if (lit > 1) multiF = 1;
        darkRun[i] = (lit == 0) ? darkRun[i] + 1 : 0;
        if (darkRun[i] > DARK_TOL) darkF = 1;
        if (kindOf(lamp[i]) == 1 &&
            (prevKind[i] == 3 || (prevKind[i] == 2 && yRun[i] < YELLOW_MIN))) shortF = 1;
        yRun[i] = lamp[i][1] ? ((yRun[i] >= YELLOW_MIN) ? YELLOW_MIN : yRun[i] + 1) : 0;
        prevKind[i] = kindOf(lamp[i]);
      end
      mCode = conflictF ? 1 : multiF ? 2 : darkF ? 3 : shortF ? 4 : 0;
      if (mCode != 0) begin
        mFault = 1; mFlash = 1; mFlashCnt = 0;
        if (mCount < 255) mCount++;
      end
    end else if (clr && n == RED && e == RED) begin
      mFault = 0; mCode = 0; mFlash = 0; mFlashCnt = 0;
      for (int i = 0; i < 2; i++) begin
        yRun[i] = 0; darkRun[i] = 0; prevKind[i] = 1;
      end
    end else begin
      mFlashCnt++;
      if (mFlashCnt == FLASH_HALF) begin
        mFlash = 1 - mFlash;
        mFlashCnt = 0;
      end
    end
  endtask

  task automatic compareOutputs();
    expect_t e;
    if (sb.size() == 0) begin
      checkOutput("scoreboard empty", 8'd1, 8'd0);
      return;
    end
    e = sb.pop_front();
    checkOutput("fault", 8'(fault), 8'(e.fault));
    checkOutput("override", 8'(override), 8'(e.override));
    checkOutput("fault_code", 8'(faultCode), 8'(e.code));
    checkOutput("flash_red", 8'(flashRed), 8'(e.flash));
    checkOutput("fault_count", faultCount, e.count);
  endtask

  // Called on a falling edge; drives one cycle, predicts, and checks at the next falling edge.
  task automatic applyStimulus(input logic [2:0] n, input logic [2:0] e, input logic clr);
    expect_t x;
    {northGreen, northYellow, northRed} = n;
    {eastGreen, eastYellow, eastRed} = e;
    faultClr = clr;
    modelStep(n, e, clr);
    x.fault = 1'(mFault); x.override = 1'(mFault); x.code = 3'(mCode);
    x.flash = 1'(mFlash); x.count = 8'(mCount);
    sb.push_back(x);
    @(posedge clk);
    @(negedge clk);
    compareOutputs();
  endtask

  // Asserts reset between clock edges and checks the outputs clear without any edge.
  task automatic resetBetweenEdges();
    #2;
    rst = 1'b0;
    #1;
    checkOutput("reset fault", 8'(fault), 8'd0);
    checkOutput("reset override", 8'(override), 8'd0);
    checkOutput("reset fault_code", 8'(faultCode), 8'd0);
    checkOutput("reset flash_red", 8'(flashRed), 8'd0);
    checkOutput("reset fault_count", faultCount, 8'd0);
    modelReset();
    sb.delete();
    {northGreen, northYellow, northRed} = RED;
    {eastGreen, eastYellow, eastRed} = RED;
    faultClr = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    logic [2:0] pick [6];
    logic [2:0] rn, re;
    pick[0] = RED; pick[1] = RED; pick[2] = GRN; pick[3] = YEL; pick[4] = DARK; pick[5] = 3'b111;

    resetBetweenEdges();

    $display("[TB] legal two-phase cycle");
    for (int rep = 0; rep < 4; rep++) begin
      for (int c = 0; c < 5; c++) applyStimulus(GRN, RED, 1'b0);
      for (int c = 0; c < 3; c++) applyStimulus(YEL, RED, 1'b0);
      for (int c = 0; c < 5; c++) applyStimulus(RED, GRN, 1'b0);
      for (int c = 0; c < 3; c++) applyStimulus(RED, YEL, 1'b0);
    end
    checkOutput("legal no fault", 8'(fault), 8'd0);
    checkOutput("legal count", faultCount, 8'd0);

    $display("[TB] conflict, flashing, clear gating");
    applyStimulus(GRN, GRN, 1'b0);
    checkOutput("conflict code", 8'(faultCode), 8'd1);
    checkOutput("conflict flash", 8'(flashRed), 8'd1);
    for (int c = 0; c < 9; c++) applyStimulus(RED, RED, 1'b0);
    applyStimulus(RED, GRN, 1'b1);
    checkOutput("clear ignored", 8'(fault), 8'd1);
    applyStimulus(RED, RED, 1'b1);
    checkOutput("cleared fault", 8'(fault), 8'd0);
    checkOutput("cleared code", 8'(faultCode), 8'd0);
    checkOutput("cleared count", faultCount, 8'd1);

    $display("[TB] short yellow");
    applyStimulus(GRN, RED, 1'b0); applyStimulus(GRN, RED, 1'b0);
    applyStimulus(YEL, RED, 1'b0); applyStimulus(YEL, RED, 1'b0);
    applyStimulus(RED, RED, 1'b0);
    checkOutput("short yellow code", 8'(faultCode), 8'd4);
    applyStimulus(RED, RED, 1'b1);
    applyStimulus(GRN, RED, 1'b0); applyStimulus(GRN, RED, 1'b0);
    for (int c = 0; c < 3; c++) applyStimulus(YEL, RED, 1'b0);
    applyStimulus(RED, RED, 1'b0); applyStimulus(RED, RED, 1'b0);
    checkOutput("full yellow ok", 8'(fault), 8'd0);
    applyStimulus(GRN, RED, 1'b0); applyStimulus(RED, RED, 1'b0);
    checkOutput("green to red code", 8'(faultCode), 8'd4);
    applyStimulus(RED, RED, 1'b1);

    $display("[TB] dark approach");
    applyStimulus(DARK, RED, 1'b0); applyStimulus(DARK, RED, 1'b0);
    applyStimulus(RED, RED, 1'b0);
    checkOutput("two dark ok", 8'(fault), 8'd0);
    for (int c = 0; c < 3; c++) applyStimulus(DARK, RED, 1'b0);
    checkOutput("dark code", 8'(faultCode), 8'd3);
    applyStimulus(RED, RED, 1'b1);

    $display("[TB] multi-lamp, held code, priority");
    applyStimulus(3'b101, RED, 1'b0);
    checkOutput("multi code", 8'(faultCode), 8'd2);
    applyStimulus(GRN, GRN, 1'b0);
    checkOutput("code held", 8'(faultCode), 8'd2);
    applyStimulus(RED, RED, 1'b1);
    applyStimulus(3'b110, GRN, 1'b0);
    checkOutput("priority code", 8'(faultCode), 8'd1);
    applyStimulus(RED, RED, 1'b1);
    applyStimulus(RED, RED, 1'b1);

    $display("[TB] random lamp patterns");
    for (int c = 0; c < 200; c++) begin
      rn = pick[$urandom_range(0, 5)];
      re = pick[$urandom_range(0, 5)];
      applyStimulus(rn, re, 1'($urandom_range(0, 2) == 0));
    end
    for (int c = 0; c < 3; c++) applyStimulus(RED, RED, 1'b1);

    $display("[TB] fault count saturation");
    for (int c = 0; c < 260; c++) begin
      applyStimulus(GRN, GRN, 1'b0);
      applyStimulus(RED, RED, 1'b1);
    end
    checkOutput("count saturated", faultCount, 8'd255);

    $display("[TB] reset mid-fault");
    applyStimulus(GRN, GRN, 1'b0);
    applyStimulus(RED, RED, 1'b0);
    resetBetweenEdges();
    applyStimulus(GRN, RED, 1'b0);
    applyStimulus(GRN, RED, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checksDone, checksFailed);
    $finish;
  end

endmodule

// File: doc/traffic_conflict_monitor.md
TRAFFIC_CONFLICT_MONITOR -- requirements
Module: traffic_conflict_monitor

Interface
REQ-001 The block SHALL expose parameter YELLOW_MIN, default 3: minimum consecutive yellow cycles before red.
REQ-002 The block SHALL expose parameter DARK_TOL, default 2: maximum consecutive cycles an approach may show no lamp.
REQ-003 The block SHALL expose parameter FLASH_HALF, default 4: flash half-period in cycles.
REQ-004 The block SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 The block SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 The block SHALL have ports north_green, north_yellow, north_red  input  1 each  north lamp drives from the light controller.
REQ-007 The block SHALL have ports east_green, east_yellow, east_red  input  1 each  east lamp drives from the light controller.
REQ-008 The block SHALL have port fault_clr  input  1  operator clear request.
REQ-009 The block SHALL have port fault  output  1  fault latched.
REQ-010 The block SHALL have port fault_code  output  3  0 none, 1 conflict, 2 multi-lamp, 3 dark, 4 short yellow.
REQ-011 The block SHALL have port override  output  1  lamp driver uses flash_red instead of controller lamps.
REQ-012 The block SHALL have port flash_red  output  1  flashing red drive for both approaches.
REQ-013 The block SHALL have port fault_count  output  8  number of fault entries, saturating.

Function
REQ-014 The block SHALL implement two states: MONITOR (checks active) and FAULT (checks suspended, flashing).
REQ-015 In MONITOR, checks SHALL evaluate the current input values each cycle; any detected fault SHALL enter FAULT at that rising edge, so fault/override are visible 1 cycle after the offending sample.
REQ-016 Conflict: both approaches have any non-red lamp lit (green or yellow) in the same cycle.
REQ-017 Multi-lamp: any approach has more than one of its three lamps lit.
REQ-018 Dark: an approach has no lamp lit for more than DARK_TOL consecutive cycles; per-approach counter, cleared by any lit lamp; exactly DARK_TOL dark cycles is legal.
REQ-019 Short yellow: an approach goes to red-only from green-only, or from yellow-only after fewer than YELLOW_MIN consecutive yellow cycles; the yellow counter saturates at YELLOW_MIN and clears when yellow is unlit.
REQ-020 Per-approach history (previous lamp, yellow count, dark count) SHALL update every MONITOR cycle.
REQ-021 Simultaneous faults SHALL latch a single code using priority conflict > multi-lamp > dark > short yellow.
REQ-022 On FAULT entry: fault=1, override=1, fault_code=the winning code, flash_red=1, flash counter=0, fault_count+1 (saturating at 255).
REQ-023 In FAULT, flash_red SHALL toggle every FLASH_HALF cycles, giving a 2*FLASH_HALF cycle period.
REQ-024 fault_clr in FAULT SHALL be honoured only in a cycle where both approaches are red-only; otherwise it SHALL be ignored with no side effect.
REQ-025 An honoured clear SHALL return to MONITOR at that edge with fault=0, override=0, fault_code=0, flash_red=0; fault_count is retained.
REQ-026 On entry to MONITOR, history SHALL be initialised to red-only with yellow and dark counts 0, so no check fires from pre-clear history.
REQ-027 fault_clr in MONITOR SHALL have no effect.
REQ-028 fault_code SHALL hold its value for the whole FAULT residence; later faults SHALL neither change the code nor increment fault_count.

Reset
REQ-029 rst low SHALL immediately, without a clock edge, force: state MONITOR, fault=0, override=0, fault_code=0, flash_red=0, fault_count=0, history red-only, all counters 0.
REQ-030 Reset asserted mid-FAULT SHALL discard the fault; after rst rises, operation resumes in MONITOR from the first rising edge.

Verification
REQ-031 Legal sequence (N green 5, yellow 3, red; E mirrored, never both non-red) for 500 ns -> fault=0, fault_count=0 throughout.
REQ-032 north_green and east_green both high at edge k -> at edge k+1: fault=1, fault_code=1, override=1, flash_red=1; flash_red toggles at k+5, k+9, ...
REQ-033 N yellow 2 cycles then red-only -> fault_code=4; a repeat with 3 yellow cycles -> no fault.
REQ-034 N all lamps low for 2 cycles -> no fault; 3 cycles -> fault_code=3 one cycle after the third dark sample.
REQ-035 In FAULT: fault_clr with E green -> ignored; fault_clr with both red-only -> fault=0, fault_code=0 at the next edge, fault_count=1.
REQ-036 rst driven low mid-FAULT between clock edges -> all outputs 0 immediately, fault_count=0.
